// File: rtl/ov7670_mem_writer.sv
// OV7670 RGB565 capture: assembles byte pairs into pixels and writes them
// into a IMG_W x IMG_H frame buffer, framed by vsync and href.
module ov7670_mem_writer #(
    parameter int IMG_W = 320,
    parameter int IMG_H = 240
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        href,
    input  logic        vsync,
    input  logic [7:0]  ov7670_data,
    output logic        we,
    output logic [16:0] wAddr,
    output logic [15:0] wData,
    output logic        frame_active,
    output logic        frame_done
);

    localparam int HW = $clog2(IMG_W + 1);
    localparam int VW = $clog2(IMG_H + 1);
    localparam logic [HW-1:0] H_LIMIT  = HW'(IMG_W);
    localparam logic [VW-1:0] V_LIMIT  = VW'(IMG_H);
    localparam logic [16:0]   LINE_INC = 17'(IMG_W);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC,
        ST_CAPTURE
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic          r_vsync_prev;
    logic          r_href_prev;
    logic [HW-1:0] r_h_cnt;
    logic [VW-1:0] r_v_cnt;
    logic          r_phase;
    logic [7:0]    r_hi_byte;
    logic [16:0]   r_line_base;
    logic          r_we;
    logic [16:0]   r_waddr;
    logic [15:0]   r_wdata;
    logic          r_frame_done;

    logic [HW-1:0] w_h_next;
    logic [VW-1:0] w_v_next;
    logic          w_phase_next;
    logic [7:0]    w_hi_next;
    logic [16:0]   w_base_next;
    logic          w_we_next;
    logic [16:0]   w_waddr_next;
    logic [15:0]   w_wdata_next;
    logic          w_done_next;

    logic w_vsync_rise;
    logic w_vsync_fall;
    logic w_href_fall;

    assign w_vsync_rise = vsync & ~r_vsync_prev;
    assign w_vsync_fall = ~vsync & r_vsync_prev;
    assign w_href_fall  = ~href & r_href_prev;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:    if (w_vsync_rise) w_state_next = ST_SYNC;
            ST_SYNC:    if (w_vsync_fall) w_state_next = ST_CAPTURE;
            ST_CAPTURE: if (w_vsync_rise) w_state_next = ST_SYNC;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    // Line base address tracks IMG_W*v_cnt incrementally, avoiding a multiplier.
    always_comb begin
        w_h_next     = r_h_cnt;
        w_v_next     = r_v_cnt;
        w_phase_next = r_phase;
        w_hi_next    = r_hi_byte;
        w_base_next  = r_line_base;
        w_we_next    = 1'b0;
        w_waddr_next = r_waddr;
        w_wdata_next = r_wdata;
        w_done_next  = 1'b0;
        case (r_state)
            ST_CAPTURE: begin
                if (w_vsync_rise) begin
                    // vsync wins over everything else, including a coincident href fall.
                    w_h_next     = '0;
                    w_v_next     = '0;
                    w_phase_next = 1'b0;
                    w_base_next  = '0;
                    w_done_next  = 1'b1;
                end else if (w_href_fall) begin
                    w_h_next     = '0;
                    w_phase_next = 1'b0;
                    if (r_v_cnt < V_LIMIT) begin
                        w_v_next    = r_v_cnt + VW'(1);
                        w_base_next = r_line_base + LINE_INC;
                    end
                end else if (!href) begin
                    w_phase_next = 1'b0;
                end else if (!r_phase) begin
                    w_hi_next    = ov7670_data;
                    w_phase_next = 1'b1;
                end else begin
                    w_phase_next = 1'b0;
                    if (r_h_cnt < H_LIMIT) begin
                        if (r_v_cnt < V_LIMIT) begin
                            w_we_next    = 1'b1;
                            w_waddr_next = r_line_base + 17'(r_h_cnt);
                            w_wdata_next = {r_hi_byte, ov7670_data};
                        end
                        w_h_next = r_h_cnt + HW'(1);
                    end
                end
            end
            default: begin
                w_h_next     = '0;
                w_v_next     = '0;
                w_phase_next = 1'b0;
                w_base_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_vsync_prev <= 1'b0;
            r_href_prev  <= 1'b0;
            r_h_cnt      <= '0;
            r_v_cnt      <= '0;
            r_phase      <= 1'b0;
            r_hi_byte    <= '0;
            r_line_base  <= '0;
            r_we         <= 1'b0;
            r_waddr      <= '0;
            r_wdata      <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_vsync_prev <= vsync;
            r_href_prev  <= href;
            r_h_cnt      <= w_h_next;
            r_v_cnt      <= w_v_next;
            r_phase      <= w_phase_next;
            r_hi_byte    <= w_hi_next;
            r_line_base  <= w_base_next;
            r_we         <= w_we_next;
            r_waddr      <= w_waddr_next;
            r_wdata      <= w_wdata_next;
            r_frame_done <= w_done_next;
        end
    end

    assign we           = r_we;
    assign wAddr        = r_waddr;
    assign wData        = r_wdata;
    assign frame_done   = r_frame_done;
    assign frame_active = (r_state == ST_CAPTURE);

endmodule

// File: tb/tb_ov7670_mem_writer.sv
// Randomised bench for ov7670_mem_writer: a line/frame-level model predicts
// every frame-buffer write and frame_done pulse.
module tb_ov7670_mem_writer;

    localparam int W = 320;
    localparam int H = 24;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        href = 1'b0;
    logic        vsync = 1'b0;
    logic [7:0]  ov7670_data = 8'h00;
    logic        we;
    logic [16:0] wAddr;
    logic [15:0] wData;
    logic        frame_active;
    logic        frame_done;

    always #5 clk = ~clk;

    ov7670_mem_writer #(.IMG_W(W), .IMG_H(H)) dut (
        .clk          (clk),
        .reset        (reset),
        .href         (href),
        .vsync        (vsync),
        .ov7670_data  (ov7670_data),
        .we           (we),
        .wAddr        (wAddr),
        .wData        (wData),
        .frame_active (frame_active),
        .frame_done   (frame_done)
    );

    typedef struct {
        logic [16:0] a;
        logic [15:0] d;
    } wr_t;

    wr_t         exp_q[$];
    logic [7:0]  lb [0:799];
    bit          capturing = 1'b0;
    int          line_idx = 0;
    int          exp_done = 0;
    int          done_cnt = 0;
    int          wr_cnt = 0;
    logic [16:0] exp_last_a = '0;
    logic [15:0] exp_last_d = '0;
    logic        prev_done = 1'b0;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: every write must be the next predicted one; idle outputs must hold.
    always @(negedge clk) begin
        if (!reset) begin
            if (we) begin
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    check("spurious_we", 32'(we), 32'd0);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("wr_addr", 32'(wAddr), 32'(e.a));
                    check("wr_data", 32'(wData), 32'(e.d));
                    exp_last_a = e.a;
                    exp_last_d = e.d;
                end
            end else begin
                check("hold_addr", 32'(wAddr), 32'(exp_last_a));
                check("hold_data", 32'(wData), 32'(exp_last_d));
            end
            if (frame_done) begin
                done_cnt++;
                check("done_width", 32'(prev_done), 32'd0);
            end
            prev_done = frame_done;
        end
    end

    task automatic drive(input logic h, input logic v, input logic [7:0] d);
        href = h;
        vsync = v;
        ov7670_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic fill_rand(input int n);
        for (int i = 0; i < n; i++) lb[i] = 8'($urandom);
    endtask

    // A line of n bytes yields floor(n/2) pixels; only the first W of them,
    // and only lines below H of a live frame, reach memory.
    task automatic model_line(input int n);
        int px;
        px = n / 2;
        if (capturing) begin
            if (line_idx < H) begin
                for (int p = 0; p < px && p < W; p++) begin
                    wr_t e;
                    e.a = 17'(W * line_idx + p);
                    e.d = {lb[2*p], lb[2*p+1]};
                    exp_q.push_back(e);
                end
            end
            line_idx++;
        end
    endtask

    task automatic model_vsync();
        if (capturing) exp_done++;
        capturing = 1'b1;
        line_idx = 0;
    endtask

    task automatic vsync_pulse();
        model_vsync();
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic send_line(input int n, input bit end_vsync);
        model_line(n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, lb[i]);
        if (end_vsync) begin
            model_vsync();
            for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 8'($urandom));
        end
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 8'($urandom));
    endtask

    task automatic abort_line(input int n);
        model_line(n);
        model_vsync();
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, lb[i]);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 8'($urandom));
        check("abort_active", 32'(frame_active), 32'd0);
        for (int i = 0; i < 2; i++) drive(1'b0, 1'b1, 8'($urandom));
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 8'($urandom));
    endtask

    task automatic do_reset();
        check("q_drained", 32'(exp_q.size()), 32'd0);
        reset = 1'b1;
        href = 1'b0;
        vsync = 1'b0;
        exp_last_a = '0;
        exp_last_d = '0;
        capturing = 1'b0;
        line_idx = 0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_we", 32'(we), 32'd0);
        check("rst_addr", 32'(wAddr), 32'd0);
        check("rst_data", 32'(wData), 32'd0);
        check("rst_active", 32'(frame_active), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
    endtask

    initial begin
        int wc0;
        int nl;
        int n;
        int kind;

        @(posedge clk);
        #1;
        do_reset();
        $display("txn reset: checks=%0d", n_checks);

        // Lines before any vsync are ignored.
        fill_rand(20);
        send_line(20, 1'b0);
        vsync_pulse();
        check("active_after_sync", 32'(frame_active), 32'd1);

        lb[0] = 8'hF8; lb[1] = 8'h00; lb[2] = 8'h07; lb[3] = 8'hE0;
        send_line(4, 1'b0);
        check("basic_addr", 32'(wAddr), 32'd1);
        check("basic_data", 32'(wData), 32'h07E0);
        $display("txn basic_line: writes=%0d", wr_cnt);

        fill_rand(3);
        send_line(3, 1'b0);
        check("odd_addr", 32'(wAddr), 32'(W));
        fill_rand(4);
        send_line(4, 1'b0);
        check("after_odd_addr", 32'(wAddr), 32'(2*W + 1));
        $display("txn odd_line: writes=%0d", wr_cnt);

        wc0 = wr_cnt;
        fill_rand(660);
        send_line(660, 1'b0);
        check("long_writes", 32'(wr_cnt - wc0), 32'(W));
        fill_rand(2);
        send_line(2, 1'b0);
        check("after_long_addr", 32'(wAddr), 32'(4*W));
        vsync_pulse();
        check("done_after_frame1", 32'(done_cnt), 32'(exp_done));
        $display("txn long_line: writes=%0d done=%0d", wr_cnt, done_cnt);

        // Full frame plus two surplus lines that must be dropped.
        wc0 = wr_cnt;
        for (int l = 0; l < H + 2; l++) begin
            fill_rand(640);
            send_line(640, 1'b0);
        end
        check("frame_writes", 32'(wr_cnt - wc0), 32'(W*H));
        check("frame_last_addr", 32'(wAddr), 32'(W*H - 1));
        vsync_pulse();
        check("frame_done_cnt", 32'(done_cnt), 32'(exp_done));
        $display("txn full_frame: writes=%0d done=%0d", wr_cnt - wc0, done_cnt);

        // Reset mid-frame: nothing is written until a fresh vsync high/low.
        for (int l = 0; l < 12; l++) begin
            fill_rand(640);
            send_line(640, 1'b0);
        end
        do_reset();
        wc0 = wr_cnt;
        for (int l = 0; l < 2; l++) begin
            fill_rand(40);
            send_line(40, 1'b0);
        end
        check("post_reset_writes", 32'(wr_cnt - wc0), 32'd0);
        vsync_pulse();
        fill_rand(2);
        send_line(2, 1'b0);
        check("post_reset_first_addr", 32'(wAddr), 32'd0);
        check("post_reset_done", 32'(done_cnt), 32'(exp_done));
        $display("txn midframe_reset: writes=%0d", wr_cnt - wc0);

        // vsync rises at pixel 50 of line 10.
        vsync_pulse();
        for (int l = 0; l < 10; l++) begin
            fill_rand(640);
            send_line(640, 1'b0);
        end
        fill_rand(100);
        abort_line(100);
        check("abort_last_addr", 32'(wAddr), 32'd3249);
        check("abort_done", 32'(done_cnt), 32'(exp_done));
        $display("txn vsync_abort: last_addr=%0d done=%0d", wAddr, done_cnt);

        // href fall and vsync rise on the same cycle.
        fill_rand(20);
        send_line(20, 1'b1);
        check("coincident_done", 32'(done_cnt), 32'(exp_done));
        check("coincident_last_addr", 32'(wAddr), 32'd9);
        fill_rand(6);
        send_line(6, 1'b0);
        check("coincident_next_addr", 32'(wAddr), 32'd2);
        $display("txn coincident_edges: done=%0d", done_cnt);

        for (int f = 0; f < 2; f++) begin
            vsync_pulse();
            nl = $urandom_range(H - 4, H + 3);
            for (int l = 0; l < nl - 1; l++) begin
                kind = $urandom_range(0, 9);
                if (kind == 0)      n = $urandom_range(0, 5);
                else if (kind == 1) n = 640;
                else if (kind == 2) n = $urandom_range(641, 700);
                else                n = $urandom_range(0, 700);
                fill_rand(n);
                send_line(n, 1'b0);
            end
            n = $urandom_range(0, 700);
            fill_rand(n);
            kind = $urandom_range(0, 2);
            if (kind == 0) begin
                send_line(n, 1'b0);
                vsync_pulse();
            end else if (kind == 1) begin
                send_line(n, 1'b1);
            end else begin
                abort_line(n);
            end
            check("rand_done", 32'(done_cnt), 32'(exp_done));
            $display("txn random_frame %0d: lines=%0d end=%0d writes=%0d", f, nl, kind, wr_cnt);
        end

        repeat (4) drive(1'b0, 1'b0, 8'h00);
        check("final_q_empty", 32'(exp_q.size()), 32'd0);
        check("final_done_count", 32'(done_cnt), 32'(exp_done));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
